sm4_stream_ctrl: RTL and testbench
==================================

Name: sm4_stream_ctrl

Overview:
Host-side initiator that drives the SM4 core's command/handshake interface.
- Accepts a key load, then a valid/ready stream of 128-bit blocks.
- Runs ECB or CBC chaining around the core and returns results on a valid/ready output stream.
- Sits between the bus/DMA front end and the SM4 core; the core port names here mirror the core's own ports.

Parameters:
TIMEOUT_CYCLES, 256, max cycles waited for core key_exp_ready or ready before abort (must be >= 2)
TO_W, 9, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
key_load_in  in  1  pulse: latch key/mode/dir and start key expansion
key_in  in  128  user key
mode_cbc_in  in  1  0=ECB, 1=CBC; latched on key_load_in
decrypt_in  in  1  0=encrypt, 1=decrypt; latched on key_load_in
iv_load_in  in  1  pulse: load chain register from iv_in
iv_in  in  128  CBC initial vector
blk_valid_in  in  1  input block valid
blk_data_in  in  128  input block
blk_ready_out  out  1  controller accepts block this cycle
res_valid_out  out  1  result valid
res_data_out  out  128  result block
res_ready_in  in  1  downstream accepts result
core_enable_key_exp_out  out  1  to core enable_key_exp_and_valid_data_in
core_user_key_out  out  128  to core user_key_in
core_encdec_enable_out  out  1  to core encdec_enable_in
core_encdec_sel_out  out  1  to core encdec_sel_in (mirrors latched decrypt)
core_data_out  out  128  to core data_in
core_key_exp_ready_in  in  1  from core key_exp_ready_out
core_ready_in  in  1  from core ready_out (one-cycle done pulse)
core_result_in  in  128  from core result_out
key_valid_out  out  1  round keys valid
busy_out  out  1  state != IDLE and != KEY_RDY
err_out  out  1  sticky timeout flag

Behaviour:
- Reset values:
  - All outputs 0, state IDLE.
  - Key, chain, mode and dir registers 0.
  - Timeout counter 0.
- States: IDLE, KEYEXP, KEY_RDY, ISSUE, WAIT, OUTPUT.
- IDLE or KEY_RDY with key_load_in=1 -> KEYEXP:
  - Latch key, mode and dir.
  - Clear key_valid_out and err_out.
  - Drive core_enable_key_exp_out=1 for exactly one cycle, with core_user_key_out stable from that cycle on.
- key_load_in in any other state is ignored.
- KEYEXP:
  - Counter increments each cycle.
  - core_key_exp_ready_in=1 -> KEY_RDY and key_valid_out=1.
  - Counter reaching TIMEOUT_CYCLES -> IDLE and err_out=1.
- iv_load_in: accepted in IDLE and KEY_RDY only; chain <= iv_in. If key_load_in and iv_load_in arrive together, both take effect.
- blk_ready_out=1 only in KEY_RDY. Handshake when blk_valid_in & blk_ready_out -> ISSUE. Block latched as in_reg; core_data_out is set by mode and dir:
  - ECB: in_reg.
  - CBC encrypt: in_reg ^ chain.
  - CBC decrypt: in_reg.
- ISSUE: core_encdec_enable_out=1 for one cycle, core_data_out held stable through WAIT; next state WAIT, counter cleared.
- WAIT: on core_ready_in, capture the result, then go to OUTPUT.
  - ECB: res = core_result_in.
  - CBC encrypt: res = core_result_in; chain <= core_result_in.
  - CBC decrypt: res = core_result_in ^ chain; chain <= in_reg.
  - Timeout -> IDLE, err_out=1, key_valid_out=0, no result emitted.
- OUTPUT: res_valid_out=1 and res_data_out held stable until res_ready_in=1, then go to KEY_RDY. If res_ready_in is already 1 on the first OUTPUT cycle, the transfer completes that cycle.
- Throughput: one block in flight. Minimum accept-to-result latency is 2 cycles plus core latency.
- core_ready_in outside WAIT: ignored. core_key_exp_ready_in outside KEYEXP: ignored.
- err_out: cleared only by reset or an accepted key_load_in.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight block and chain state are lost.

Decomposition:
- Package sm4_ctrl_pkg:
  - State enum.
  - BLK_W=128.
  - Mode/dir encodings.
- Sub-module sm4_chain_xor: combinational pre/post CBC XOR select plus the chain register update.
- FSM and timeout counter stay in the top-level block.

Test Plan:
1. Key load, key=0123456789abcdeffedcba9876543210, ECB encrypt, block=same value -> one-cycle core_enable_key_exp_out pulse; key_valid_out=1 after the core reports ready; res_data_out=681edf34d206965e86b3e94f536e4246.
2. ECB decrypt with the same key, block=681edf34d206965e86b3e94f536e4246 -> res_data_out=0123456789abcdeffedcba9876543210.
3. CBC encrypt then CBC decrypt of two blocks, IV=000102030405060708090a0b0c0d0e0f -> decrypted blocks equal the originals; core_data_out for block 2 equals P2 ^ C1.
4. Backpressure: hold res_ready_in=0 for 10 cycles -> res_valid_out and res_data_out stay stable, blk_ready_out=0; release -> transfer completes, blk_ready_out=1 next cycle.
5. Core never asserts ready; TIMEOUT_CYCLES=16 -> after 16 WAIT cycles state IDLE, err_out=1, key_valid_out=0; a following key_load_in clears err_out.
6. Assert reset during WAIT and issue key_load_in during OUTPUT -> reset returns all outputs to 0 immediately; key_load_in during OUTPUT is ignored, with key and mode unchanged.

Source files
------------

// File: rtl/sm4_ctrl_pkg.sv
// Shared types and constants for the SM4 stream controller.
package sm4_ctrl_pkg;

  localparam int BLK_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_KEY_RDY,
    ST_ISSUE,
    ST_WAIT,
    ST_OUTPUT
  } state_t;

  typedef enum logic {
    MODE_ECB = 1'b0,
    MODE_CBC = 1'b1
  } mode_t;

  typedef enum logic {
    DIR_ENC = 1'b0,
    DIR_DEC = 1'b1
  } dir_t;

endpackage

// File: rtl/sm4_chain_xor.sv
// CBC chaining around the core: pre-core XOR for encrypt, post-core XOR for
// decrypt, and the chain register that carries state between blocks.
module sm4_chain_xor
  import sm4_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_cbc,
  input  logic             decrypt,
  input  logic             iv_load,
  input  logic [BLK_W-1:0] iv,
  input  logic [BLK_W-1:0] blk,
  input  logic [BLK_W-1:0] in_reg,
  input  logic [BLK_W-1:0] core_result,
  input  logic             capture,
  output logic [BLK_W-1:0] pre_data,
  output logic [BLK_W-1:0] post_data
);

  logic [BLK_W-1:0] chain;

  // Select data sent to the core and result returned to the host.
  always_comb begin
    pre_data  = blk;
    post_data = core_result;
    if (mode_cbc && !decrypt) pre_data  = blk ^ chain;
    if (mode_cbc && decrypt)  post_data = core_result ^ chain;
  end

  // Chain register: IV load, or advance on each captured CBC result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else if (iv_load) begin
      chain <= iv;
    end else if (capture && mode_cbc) begin
      chain <= decrypt ? in_reg : core_result;
    end
  end

endmodule

// File: rtl/sm4_stream_ctrl.sv
// Host-side initiator for the SM4 core: key load, one block in flight,
// ECB/CBC chaining, valid/ready streams and a cycle timeout on the core.
module sm4_stream_ctrl
  import sm4_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_W           = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_load_in,
  input  logic [127:0] key_in,
  input  logic         mode_cbc_in,
  input  logic         decrypt_in,
  input  logic         iv_load_in,
  input  logic [127:0] iv_in,
  input  logic         blk_valid_in,
  input  logic [127:0] blk_data_in,
  output logic         blk_ready_out,
  output logic         res_valid_out,
  output logic [127:0] res_data_out,
  input  logic         res_ready_in,
  output logic         core_enable_key_exp_out,
  output logic [127:0] core_user_key_out,
  output logic         core_encdec_enable_out,
  output logic         core_encdec_sel_out,
  output logic [127:0] core_data_out,
  input  logic         core_key_exp_ready_in,
  input  logic         core_ready_in,
  input  logic [127:0] core_result_in,
  output logic         key_valid_out,
  output logic         busy_out,
  output logic         err_out
);

  state_t           state, state_next;
  logic [TO_W-1:0]  to_cnt, to_cnt_inc;
  logic             to_hit;
  logic             accept_key, accept_blk, key_done, capture, timeout, cnt_clr;
  logic             iv_accept;
  mode_t            mode_q;
  dir_t             dir_q;
  logic [BLK_W-1:0] key_q, in_reg, core_data_q, res_q, pre_data, post_data;
  logic             key_exp_pulse, key_valid_q, err_q;

  assign to_cnt_inc = to_cnt + TO_W'(1);
  assign to_hit     = (to_cnt_inc == TO_W'(TIMEOUT_CYCLES));
  assign iv_accept  = iv_load_in && (state == ST_IDLE || state == ST_KEY_RDY);

  sm4_chain_xor u_chain (
    .clk         (clk),
    .rst         (reset),
    .mode_cbc    (mode_q == MODE_CBC),
    .decrypt     (dir_q == DIR_DEC),
    .iv_load     (iv_accept),
    .iv          (iv_in),
    .blk         (blk_data_in),
    .in_reg      (in_reg),
    .core_result (core_result_in),
    .capture     (capture),
    .pre_data    (pre_data),
    .post_data   (post_data)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic and single-cycle control strobes.
  always_comb begin
    state_next = state;
    accept_key = 1'b0;
    accept_blk = 1'b0;
    key_done   = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      ST_IDLE, ST_KEY_RDY: begin
        if (key_load_in) begin
          accept_key = 1'b1;
          cnt_clr    = 1'b1;
          state_next = ST_KEYEXP;
        end else if (state == ST_KEY_RDY && blk_valid_in) begin
          accept_blk = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_KEYEXP: begin
        if (core_key_exp_ready_in) begin
          key_done   = 1'b1;
          state_next = ST_KEY_RDY;
        end else if (to_hit) begin
          timeout    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_clr    = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_ready_in) begin
          capture    = 1'b1;
          state_next = ST_OUTPUT;
        end else if (to_hit) begin
          timeout    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_OUTPUT: begin
        if (res_ready_in) state_next = ST_KEY_RDY;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Timeout counter: counts cycles spent waiting on the core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (cnt_clr) begin
      to_cnt <= '0;
    end else if (state == ST_KEYEXP || state == ST_WAIT) begin
      to_cnt <= to_cnt_inc;
    end
  end

  // Key/mode latch, block latch, core data and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_exp_pulse <= 1'b0;
      key_q         <= '0;
      mode_q        <= MODE_ECB;
      dir_q         <= DIR_ENC;
      in_reg        <= '0;
      core_data_q   <= '0;
      res_q         <= '0;
    end else begin
      key_exp_pulse <= accept_key;
      if (accept_key) begin
        key_q  <= key_in;
        mode_q <= mode_t'(mode_cbc_in);
        dir_q  <= dir_t'(decrypt_in);
      end
      if (accept_blk) begin
        in_reg      <= blk_data_in;
        core_data_q <= pre_data;
      end
      if (capture) res_q <= post_data;
    end
  end

  // Status flags: key validity and sticky timeout error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (accept_key) begin
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (key_done) begin
      key_valid_q <= 1'b1;
    end else if (timeout) begin
      key_valid_q <= 1'b0;
      err_q       <= 1'b1;
    end
  end

  assign blk_ready_out           = (state == ST_KEY_RDY);
  assign res_valid_out           = (state == ST_OUTPUT);
  assign res_data_out            = res_q;
  assign core_enable_key_exp_out = key_exp_pulse;
  assign core_user_key_out       = key_q;
  assign core_encdec_enable_out  = (state == ST_ISSUE);
  assign core_encdec_sel_out     = (dir_q == DIR_DEC);
  assign core_data_out           = core_data_q;
  assign key_valid_out           = key_valid_q;
  assign busy_out                = (state != ST_IDLE) && (state != ST_KEY_RDY);
  assign err_out                 = err_q;

endmodule

// File: tb/tb_sm4_stream_ctrl.sv
// Self-checking bench for sm4_stream_ctrl with a behavioural SM4 core and a
// block-level ECB/CBC reference model.
module tb_sm4_stream_ctrl;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         key_load_in = 1'b0;
  logic [127:0] key_in = '0;
  logic         mode_cbc_in = 1'b0;
  logic         decrypt_in = 1'b0;
  logic         iv_load_in = 1'b0;
  logic [127:0] iv_in = '0;
  logic         blk_valid_in = 1'b0;
  logic [127:0] blk_data_in = '0;
  logic         blk_ready_out;
  logic         res_valid_out;
  logic [127:0] res_data_out;
  logic         res_ready_in = 1'b0;
  logic         core_enable_key_exp_out;
  logic [127:0] core_user_key_out;
  logic         core_encdec_enable_out;
  logic         core_encdec_sel_out;
  logic [127:0] core_data_out;
  logic         core_key_exp_ready_in = 1'b0;
  logic         core_ready_in = 1'b0;
  logic [127:0] core_result_in = '0;
  logic         key_valid_out;
  logic         busy_out;
  logic         err_out;

  int n_checks = 0;
  int n_fail   = 0;

  sm4_stream_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .key_load_in             (key_load_in),
    .key_in                  (key_in),
    .mode_cbc_in             (mode_cbc_in),
    .decrypt_in              (decrypt_in),
    .iv_load_in              (iv_load_in),
    .iv_in                   (iv_in),
    .blk_valid_in            (blk_valid_in),
    .blk_data_in             (blk_data_in),
    .blk_ready_out           (blk_ready_out),
    .res_valid_out           (res_valid_out),
    .res_data_out            (res_data_out),
    .res_ready_in            (res_ready_in),
    .core_enable_key_exp_out (core_enable_key_exp_out),
    .core_user_key_out       (core_user_key_out),
    .core_encdec_enable_out  (core_encdec_enable_out),
    .core_encdec_sel_out     (core_encdec_sel_out),
    .core_data_out           (core_data_out),
    .core_key_exp_ready_in   (core_key_exp_ready_in),
    .core_ready_in           (core_ready_in),
    .core_result_in          (core_result_in),
    .key_valid_out           (key_valid_out),
    .busy_out                (busy_out),
    .err_out                 (err_out)
  );

  always #5 clk = ~clk;

  // ---------------- SM4 cipher (behavioural) ----------------
  logic [7:0] sbox [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {sbox[a[31:24]], sbox[a[23:16]], sbox[a[15:8]], sbox[a[7:0]]};
  endfunction

  function automatic logic [1023:0] sm4_expand(input logic [127:0] key);
    logic [31:0] k [36];
    logic [31:0] ck, t;
    logic [1023:0] rk;
    k[0] = key[127:96] ^ 32'ha3b1bac6;
    k[1] = key[95:64]  ^ 32'h56aa3350;
    k[2] = key[63:32]  ^ 32'h677d9197;
    k[3] = key[31:0]   ^ 32'hb27022dc;
    rk = '0;
    for (int i = 0; i < 32; i++) begin
      ck = {8'((4*i)*7), 8'((4*i+1)*7), 8'((4*i+2)*7), 8'((4*i+3)*7)};
      t = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ t ^ rol(t, 13) ^ rol(t, 23);
      rk[i*32 +: 32] = k[i+4];
    end
    return rk;
  endfunction

  function automatic logic [127:0] sm4_crypt(input logic [127:0] d, input logic [1023:0] rk,
                                             input logic dec);
    logic [31:0] x [36];
    logic [31:0] r, t;
    x[0] = d[127:96]; x[1] = d[95:64]; x[2] = d[63:32]; x[3] = d[31:0];
    for (int i = 0; i < 32; i++) begin
      r = dec ? rk[(31-i)*32 +: 32] : rk[i*32 +: 32];
      t = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ r);
      x[i+4] = x[i] ^ t ^ rol(t, 2) ^ rol(t, 10) ^ rol(t, 18) ^ rol(t, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  // ---------------- Core model ----------------
  bit            core_dead = 1'b0;
  logic [1023:0] core_rk = '0;
  logic [127:0]  core_res = '0;
  logic [2:0]    kcnt = '0;
  logic [2:0]    ccnt = '0;

  always @(posedge clk) begin
    core_key_exp_ready_in <= 1'b0;
    core_ready_in         <= 1'b0;
    if (core_enable_key_exp_out) begin
      core_rk <= sm4_expand(core_user_key_out);
      kcnt    <= 3'd3;
    end else if (kcnt != 0) begin
      kcnt <= kcnt - 3'd1;
      if (kcnt == 3'd1 && !core_dead) core_key_exp_ready_in <= 1'b1;
    end
    if (core_encdec_enable_out) begin
      core_res <= sm4_crypt(core_data_out, core_rk, core_encdec_sel_out);
      ccnt     <= 3'($urandom_range(1, 4));
    end else if (ccnt != 0) begin
      ccnt <= ccnt - 3'd1;
      if (ccnt == 3'd1 && !core_dead) begin
        core_ready_in  <= 1'b1;
        core_result_in <= core_res;
      end
    end
  end

  // ---------------- Reference model state ----------------
  logic [127:0] m_key   = '0;
  logic [127:0] m_chain = '0;
  logic         m_cbc   = 1'b0;
  logic         m_dec   = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_blk_ready"}, 128'(blk_ready_out), 128'd0);
    check({pfx, "_res_valid"}, 128'(res_valid_out), 128'd0);
    check({pfx, "_res_data"}, res_data_out, 128'd0);
    check({pfx, "_key_valid"}, 128'(key_valid_out), 128'd0);
    check({pfx, "_busy"}, 128'(busy_out), 128'd0);
    check({pfx, "_err"}, 128'(err_out), 128'd0);
    check({pfx, "_kexp"}, 128'(core_enable_key_exp_out), 128'd0);
    check({pfx, "_encdec_en"}, 128'(core_encdec_enable_out), 128'd0);
    check({pfx, "_sel"}, 128'(core_encdec_sel_out), 128'd0);
    check({pfx, "_user_key"}, core_user_key_out, 128'd0);
    check({pfx, "_core_data"}, core_data_out, 128'd0);
  endtask

  task automatic load_key(input logic [127:0] k, input logic cbc, input logic dec,
                          input logic with_iv, input logic [127:0] iv);
    int n;
    key_load_in = 1'b1; key_in = k; mode_cbc_in = cbc; decrypt_in = dec;
    iv_load_in = with_iv; iv_in = iv;
    tick();
    key_load_in = 1'b0; iv_load_in = 1'b0;
    m_key = k; m_cbc = cbc; m_dec = dec;
    if (with_iv) m_chain = iv;
    check("kexp_pulse", 128'(core_enable_key_exp_out), 128'd1);
    check("user_key", core_user_key_out, k);
    check("sel", 128'(core_encdec_sel_out), 128'(dec));
    check("err_cleared", 128'(err_out), 128'd0);
    tick();
    check("kexp_pulse_len", 128'(core_enable_key_exp_out), 128'd0);
    n = 0;
    while (!key_valid_out && n < 40) begin tick(); n++; end
    check("key_valid", 128'(key_valid_out), 128'd1);
  endtask

  task automatic load_iv(input logic [127:0] iv);
    iv_load_in = 1'b1; iv_in = iv;
    tick();
    iv_load_in = 1'b0;
    m_chain = iv;
  endtask

  task automatic send_block(input logic [127:0] p, output logic [127:0] r,
                            input int bp, input bit poke);
    logic [1023:0] rk;
    logic [127:0]  exp_core, exp_res;
    int n;
    rk = sm4_expand(m_key);
    if (!m_cbc) begin
      exp_core = p;
      exp_res  = sm4_crypt(p, rk, m_dec);
    end else if (!m_dec) begin
      exp_core = p ^ m_chain;
      exp_res  = sm4_crypt(exp_core, rk, 1'b0);
      m_chain  = exp_res;
    end else begin
      exp_core = p;
      exp_res  = sm4_crypt(p, rk, 1'b1) ^ m_chain;
      m_chain  = p;
    end
    blk_valid_in = 1'b1; blk_data_in = p; res_ready_in = (bp == 0);
    n = 0;
    while (!blk_ready_out && n < 20) begin tick(); n++; end
    check("blk_ready", 128'(blk_ready_out), 128'd1);
    tick();
    blk_valid_in = 1'b0; blk_data_in = rnd128();
    check("issue_en", 128'(core_encdec_enable_out), 128'd1);
    check("core_data", core_data_out, exp_core);
    n = 0;
    while (!res_valid_out && n < 40) begin tick(); n++; end
    check("res_valid", 128'(res_valid_out), 128'd1);
    check("res_data", res_data_out, exp_res);
    for (int i = 0; i < bp; i++) begin
      if (poke && i == 0) begin
        key_load_in = 1'b1; key_in = ~m_key; mode_cbc_in = !m_cbc; decrypt_in = !m_dec;
      end
      tick();
      key_load_in = 1'b0;
      check("hold_valid", 128'(res_valid_out), 128'd1);
      check("hold_data", res_data_out, exp_res);
      check("hold_blk_ready", 128'(blk_ready_out), 128'd0);
      if (poke && i == 0) begin
        check("poke_kexp", 128'(core_enable_key_exp_out), 128'd0);
        check("poke_key", core_user_key_out, m_key);
        check("poke_sel", 128'(core_encdec_sel_out), 128'(m_dec));
      end
    end
    res_ready_in = 1'b1;
    r = res_data_out;
    tick();
    res_ready_in = 1'b0;
    check("res_done", 128'(res_valid_out), 128'd0);
    check("blk_ready_after", 128'(blk_ready_out), 128'd1);
  endtask

  // ---------------- Stimulus ----------------
  initial begin
    logic [127:0] kat_key, kat_ct, iv0, p1, p2, c1, c2, r, k;
    int n;
    kat_key = 128'h0123456789abcdeffedcba9876543210;
    kat_ct  = 128'h681edf34d206965e86b3e94f536e4246;
    iv0     = 128'h000102030405060708090a0b0c0d0e0f;

    tick(); tick();
    check_zero_outputs("rst");
    reset = 1'b0;
    tick();

    load_key(kat_key, 1'b0, 1'b0, 1'b0, '0);
    send_block(kat_key, r, 2, 1'b0);
    check("ecb_kat_enc", r, kat_ct);

    load_key(kat_key, 1'b0, 1'b1, 1'b0, '0);
    send_block(kat_ct, r, 1, 1'b0);
    check("ecb_kat_dec", r, kat_key);

    p1 = rnd128(); p2 = rnd128();
    load_key(kat_key, 1'b1, 1'b0, 1'b1, iv0);
    send_block(p1, c1, 0, 1'b0);
    send_block(p2, c2, 3, 1'b0);
    load_key(kat_key, 1'b1, 1'b1, 1'b1, iv0);
    send_block(c1, r, 0, 1'b0);
    check("cbc_rt1", r, p1);
    send_block(c2, r, 1, 1'b0);
    check("cbc_rt2", r, p2);

    for (int t = 0; t < 4; t++) begin
      load_key(rnd128(), 1'($urandom), 1'($urandom), 1'b1, rnd128());
      for (int b = 0; b < 4; b++) begin
        send_block(rnd128(), r, int'($urandom_range(0, 3)), 1'b0);
        if ($urandom_range(0, 3) == 0) load_iv(rnd128());
      end
    end

    load_key(rnd128(), 1'b0, 1'b0, 1'b0, '0);
    send_block(rnd128(), r, 10, 1'b0);

    load_key(rnd128(), 1'b1, 1'b0, 1'b1, rnd128());
    send_block(rnd128(), r, 3, 1'b1);
    send_block(rnd128(), r, 0, 1'b0);

    // Reset while waiting on the core.
    load_key(rnd128(), 1'b0, 1'b0, 1'b0, '0);
    blk_valid_in = 1'b1; blk_data_in = rnd128();
    n = 0;
    while (!blk_ready_out && n < 20) begin tick(); n++; end
    tick();
    blk_valid_in = 1'b0;
    tick();
    check("busy_wait", 128'(busy_out), 128'd1);
    #2 reset = 1'b1;
    #1 check_zero_outputs("midrst");
    @(posedge clk);
    #1 reset = 1'b0;
    m_chain = '0;
    tick();
    check("post_rst_busy", 128'(busy_out), 128'd0);
    check("post_rst_blk_ready", 128'(blk_ready_out), 128'd0);

    // Core never answers a block: WAIT timeout.
    load_key(rnd128(), 1'b0, 1'b1, 1'b0, '0);
    core_dead = 1'b1;
    blk_valid_in = 1'b1; blk_data_in = rnd128();
    n = 0;
    while (!blk_ready_out && n < 20) begin tick(); n++; end
    tick();
    blk_valid_in = 1'b0;
    tick();
    for (int i = 1; i < TO; i++) tick();
    check("wait_no_early_err", 128'(err_out), 128'd0);
    check("wait_busy", 128'(busy_out), 128'd1);
    tick();
    check("wait_to_err", 128'(err_out), 128'd1);
    check("wait_to_key_valid", 128'(key_valid_out), 128'd0);
    check("wait_to_idle", 128'(busy_out), 128'd0);
    check("wait_to_no_res", 128'(res_valid_out), 128'd0);
    check("wait_to_blk_ready", 128'(blk_ready_out), 128'd0);
    core_dead = 1'b0;
    repeat (5) tick();
    load_key(rnd128(), 1'b0, 1'b0, 1'b0, '0);
    send_block(rnd128(), r, 1, 1'b0);

    // Core never finishes key expansion: KEYEXP timeout.
    core_dead = 1'b1;
    k = rnd128();
    key_load_in = 1'b1; key_in = k;
    tick();
    key_load_in = 1'b0;
    for (int i = 1; i < TO; i++) tick();
    check("kexp_no_early_err", 128'(err_out), 128'd0);
    check("kexp_busy", 128'(busy_out), 128'd1);
    tick();
    check("kexp_to_err", 128'(err_out), 128'd1);
    check("kexp_to_key_valid", 128'(key_valid_out), 128'd0);
    check("kexp_to_idle", 128'(busy_out), 128'd0);
    core_dead = 1'b0;
    repeat (5) tick();
    load_key(rnd128(), 1'b1, 1'b1, 1'b1, rnd128());
    send_block(rnd128(), r, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
